uart_tx_arbiter: RTL
====================

Name: uart_tx_arbiter

Overview:
- Round-robin arbiter sharing one UART transmit FIFO write port between NUM_REQ packet sources, e.g. the move encoder, the board-state dumper and the debug echo path.
- Each source owns the FIFO for a whole packet, so bytes from different sources never interleave on the line.
- Sits directly in front of uart_tx_fifo. It drives wr_tx_pin and w_data, and takes tx_full back as backpressure.
- Includes a stall watchdog and a maximum packet length guard, so one misbehaving source cannot lock out the others.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- MAX_LEN, 64, maximum bytes per grant; the grant is force-released after this many accepted bytes.
- TIMEOUT, 255, maximum consecutive cycles a granted requester may hold req low before the grant is revoked.
- CNT_W, 8, width of the byte counter and the stall counter; must hold both MAX_LEN and TIMEOUT.

Ports:
- clk  in  1  system clock.
- reset_pin  in  1  asynchronous reset, active-high.
- req  in  NUM_REQ  per-requester "byte valid"; bit i belongs to requester i.
- data  in  8*NUM_REQ  per-requester byte; requester i uses bits [8i+7:8i].
- last  in  NUM_REQ  per-requester end-of-packet flag, qualified by req.
- ack  out  NUM_REQ  byte accepted from requester i in this cycle (combinational).
- gnt  out  NUM_REQ  one-hot registered grant.
- tx_full  in  1  FIFO full flag from uart_tx_fifo.
- wr_tx_pin  out  1  FIFO write strobe (combinational).
- w_data  out  8  FIFO write data.
- err_stall  out  1  one-cycle pulse when a grant is revoked by the stall watchdog.
- err_len  out  1  one-cycle pulse when a grant is released by MAX_LEN without a last byte.

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - state = IDLE, gnt = 0, round-robin pointer ptr = NUM_REQ-1.
  - Byte counter and stall counter = 0; err_stall = err_len = 0.
  - Because ack and wr_tx_pin depend on gnt, both are 0 during reset.
- Accept condition:
  - accept_i = gnt[i] & req[i] & ~tx_full.
  - ack[i] = accept_i; wr_tx_pin = OR of all accept_i.
  - w_data = data of the granted requester; it is 0 when gnt = 0.
  - An accepted byte is written on the same cycle, with zero latency.
  - Requesters must keep data and last stable while req is high and ack is low.
- IDLE state:
  - If any req bit is set, select the first index with req set, searching from ptr+1 upward and wrapping modulo NUM_REQ.
  - Register gnt to that index (one-hot), clear both counters, and go to BUSY.
  - No byte is accepted in the arbitration cycle, so the first byte lands at the earliest one cycle after req rises.
- BUSY state, evaluated each cycle:
  - An accepted byte increments the byte counter and clears the stall counter.
  - If req of the granted requester is low, the stall counter increments. A tx_full stall does not count as a requester stall.
- BUSY release conditions (checked in priority order); each one returns to IDLE next cycle with gnt = 0 and ptr = granted index:
  1. Accepted byte with last = 1.
  2. Accepted byte that makes the byte counter equal MAX_LEN; err_len pulses if last = 0.
  3. Stall counter reaches TIMEOUT; err_stall pulses.
- The IDLE cycle after each release guarantees a one-cycle gap, so re-arbitration is fair: a requester that just finished has the lowest priority.
- Requests from non-granted requesters are ignored while BUSY: their ack stays 0 and their bytes are held.
- tx_full held high indefinitely: the grant is kept, no bytes are accepted, and no error is raised.
- Single-byte packet (req and last together): accepted and released in one BUSY cycle.
- MAX_LEN release with last = 1 on the same byte: treated as a normal end of packet, with no err_len.
- Reset asserted mid-packet: the grant is dropped immediately and the bytes already in the FIFO are unaffected. Requesters must restart their packet.

Test Plan:
1. Single requester, 3-byte packet: req[0] = 1 with bytes 0xA1, 0xA2, 0xA3 (last on 0xA3), tx_full = 0.
   - gnt = 0001 one cycle after req.
   - Three consecutive wr_tx_pin pulses with w_data = A1, A2, A3.
   - gnt = 0 on the next cycle.
2. All four requesters request continuously with 1-byte packets.
   - Grant order after reset is 0, 1, 2, 3, 0, …
   - Exactly one write every two cycles.
   - Bytes never interleave.
3. Backpressure: tx_full = 1 for 10 cycles in the middle of a 4-byte packet.
   - No writes and ack = 0 during those cycles.
   - The grant is held and err_stall stays 0.
   - The remaining bytes are written after tx_full falls.
4. Stall: requester 1 is granted, sends 1 byte, then drops req; TIMEOUT = 255.
   - err_stall pulses exactly 255 cycles after req falls.
   - gnt = 0 the next cycle.
   - A pending requester 2 is granted next.
5. Length guard: MAX_LEN = 4, requester 2 streams 6 bytes with no last.
   - Bytes 1–4 are written, then err_len pulses on the 4th accepted byte.
   - Pending requester 3 is granted.
   - Requester 2 regains the grant later.
6. Assert reset_pin mid-packet (between bytes 2 and 3).
   - gnt, wr_tx_pin and ack go to 0 asynchronously.
   - After release, arbitration restarts at index 0.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that gives one packet source at a time the write port of uart_tx_fifo.
// A grant lasts for a whole packet and can be cut short by the length guard or the stall watchdog.
module uart_tx_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int MAX_LEN = 64,
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 8
) (
    input  logic                   clk,
    input  logic                   reset_pin,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [8*NUM_REQ-1:0]   data,
    input  logic [NUM_REQ-1:0]     last,
    output logic [NUM_REQ-1:0]     ack,
    output logic [NUM_REQ-1:0]     gnt,
    input  logic                   tx_full,
    output logic                   wr_tx_pin,
    output logic [7:0]             w_data,
    output logic                   err_stall,
    output logic                   err_len
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t             state, state_next;
    logic [NUM_REQ-1:0] gnt_next;
    logic [IDX_W-1:0]   cur_idx, idx_next;
    logic [IDX_W-1:0]   ptr, ptr_next;
    logic [IDX_W-1:0]   pick_idx;
    logic               pick_valid;
    logic [CNT_W-1:0]   byte_cnt, byte_next, byte_inc;
    logic [CNT_W-1:0]   stall_cnt, stall_next;
    logic [NUM_REQ-1:0] accept;
    logic               rel;

    assign accept    = gnt & req & {NUM_REQ{~tx_full}};
    assign ack       = accept;
    assign wr_tx_pin = |accept;
    assign byte_inc  = byte_cnt + 1'b1;

    // Only the granted slice can pass; with no grant the write data is zero.
    always_comb begin
        w_data = 8'h00;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_data = w_data | (data[8*i +: 8] & {8{gnt[i]}});
        end
    end

    // Search starts just after the last owner, so whoever finished last has lowest priority.
    always_comb begin
        int cand;
        cand       = 0;
        pick_valid = 1'b0;
        pick_idx   = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = (int'(ptr) + k) % NUM_REQ;
            if (!pick_valid && req[IDX_W'(cand)]) begin
                pick_valid = 1'b1;
                pick_idx   = IDX_W'(cand);
            end
        end
    end

    always_ff @(posedge clk or posedge reset_pin) begin
        if (reset_pin) begin
            state     <= IDLE;
            gnt       <= '0;
            cur_idx   <= '0;
            ptr       <= IDX_W'(NUM_REQ - 1);
            byte_cnt  <= '0;
            stall_cnt <= '0;
        end else begin
            state     <= state_next;
            gnt       <= gnt_next;
            cur_idx   <= idx_next;
            ptr       <= ptr_next;
            byte_cnt  <= byte_next;
            stall_cnt <= stall_next;
        end
    end

    // Release priority: end of packet, then length guard, then stall watchdog.
    always_comb begin
        state_next = state;
        gnt_next   = gnt;
        idx_next   = cur_idx;
        ptr_next   = ptr;
        byte_next  = byte_cnt;
        stall_next = stall_cnt;
        err_stall  = 1'b0;
        err_len    = 1'b0;
        rel        = 1'b0;
        case (state)
            IDLE: begin
                if (pick_valid) begin
                    state_next         = BUSY;
                    gnt_next           = '0;
                    gnt_next[pick_idx] = 1'b1;
                    idx_next           = pick_idx;
                    byte_next          = '0;
                    stall_next         = '0;
                end
            end
            BUSY: begin
                if (wr_tx_pin) begin
                    byte_next  = byte_inc;
                    stall_next = '0;
                end else if (!req[cur_idx]) begin
                    stall_next = stall_cnt + 1'b1;
                end
                if (wr_tx_pin && last[cur_idx]) begin
                    rel = 1'b1;
                end else if (wr_tx_pin && (byte_inc == CNT_W'(MAX_LEN))) begin
                    rel     = 1'b1;
                    err_len = 1'b1;
                end else if (!wr_tx_pin && (stall_cnt == CNT_W'(TIMEOUT))) begin
                    rel       = 1'b1;
                    err_stall = 1'b1;
                end
                if (rel) begin
                    state_next = IDLE;
                    gnt_next   = '0;
                    ptr_next   = cur_idx;
                end
            end
            default: state_next = IDLE;
        endcase
    end

endmodule
